// File: rtl/chess_pkg.sv
// Shared chess definitions: square/type codes, scanner FSM states and the type legality check.
package chess_pkg;

    localparam int unsigned SQUARES = 64;
    localparam int unsigned POS_W   = 6;
    localparam int unsigned CODE_W  = 6;
    localparam int unsigned TYPE_W  = 5;
    localparam int unsigned CNT_W   = 5;

    localparam logic [TYPE_W-1:0] EMPTY  = 5'b00000;
    localparam logic [TYPE_W-1:0] KNIGHT = 5'b00001;
    localparam logic [TYPE_W-1:0] PAWN   = 5'b00010;
    localparam logic [TYPE_W-1:0] KING   = 5'b00100;
    localparam logic [TYPE_W-1:0] BISHOP = 5'b01000;
    localparam logic [TYPE_W-1:0] ROOK   = 5'b10000;
    localparam logic [TYPE_W-1:0] QUEEN  = 5'b11000;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CHECK = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

    // True for any of the defined type codes, EMPTY included.
    function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
        case (t)
            EMPTY, KNIGHT, PAWN, KING, BISHOP, ROOK, QUEEN: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/board_scanner.sv
// Board scanner: walks the 64 board squares and hands qualifying squares to the ray transmitter
// under a valid/ready handshake. Optional own-colour filter: BOARD_SCAN_FILTER_EN.
module board_scanner
    import chess_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              engine_color,
    output logic              brd_rd_en,
    output logic [POS_W-1:0]  brd_addr,
    input  logic [CODE_W-1:0] brd_rdata,
    output logic [CODE_W-1:0] piece_reg,
    output logic [POS_W-1:0]  pos_reg,
    output logic              pc_valid,
    input  logic              pc_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  piece_count
);

    scan_state_e       state_q, state_d;
    logic [POS_W-1:0]  addr_q, addr_d;
    logic              color_q, color_d;
    logic [CODE_W-1:0] piece_q, piece_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [POS_W-1:0]  baddr_q;
    logic              rd_en_q, valid_q, busy_q, done_q;
    logic              qualifies_c;
    logic              last_c;

    // Square qualification on the freshly read code.
`ifdef BOARD_SCAN_FILTER_EN
    assign qualifies_c = (brd_rdata[TYPE_W-1:0] != EMPTY)
                       && is_legal_type(brd_rdata[TYPE_W-1:0])
                       && (brd_rdata[CODE_W-1] == color_q);
`else
    logic unused_color_c;
    assign unused_color_c = color_q;
    assign qualifies_c    = 1'b1;
`endif

    assign last_c = (addr_q == POS_W'(SQUARES - 1));

    // Next-state, address counter and payload capture; abort overrides everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        color_d = color_q;
        piece_d = piece_q;
        pos_d   = pos_q;
        count_d = count_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        color_d = engine_color;
                        count_d = '0;
                        addr_d  = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_CHECK;
                ST_CHECK: begin
                    piece_d = brd_rdata;
                    pos_d   = addr_q;
                    if (qualifies_c) begin
                        state_d = ST_EMIT;
                    end else if (last_c) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + POS_W'(1);
                        state_d = ST_FETCH;
                    end
                end
                ST_EMIT: begin
                    if (pc_ready) begin
                        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        if (last_c) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + POS_W'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; strobes are decoded from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            color_q <= 1'b0;
            piece_q <= '0;
            pos_q   <= '0;
            count_q <= '0;
            baddr_q <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            color_q <= color_d;
            piece_q <= piece_d;
            pos_q   <= pos_d;
            count_q <= count_d;
            rd_en_q <= (state_d == ST_FETCH);
            if (state_d == ST_FETCH) begin
                baddr_q <= addr_d;
            end
            valid_q <= (state_d == ST_EMIT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign brd_rd_en   = rd_en_q;
    assign brd_addr    = baddr_q;
    assign piece_reg   = piece_q;
    assign pos_reg     = pos_q;
    assign pc_valid    = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign piece_count = count_q;

endmodule

// File: doc/board_scanner.md
# board_scanner

Sequential square scanner that sits directly upstream of the move-ray transmitter. On a start pulse it walks the 64-square board memory, reads one 6-bit square code per access, and presents each qualifying square as a stable `piece_reg`/`pos_reg` pair under a valid/ready handshake. The transmitter consumes this pair to fan out directional rays. The scanner reports completion and a count of forwarded pieces to the engine controller.

## Interface
- `SQUARES`, 64, number of board squares scanned (addresses 0..SQUARES-1).
- `POS_W`, 6, width of square address / `pos_reg`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE without `done`.
- `engine_color`  in  1  side to move (1 = white, 0 = black); latched at start.
- `brd_rd_en`  out  1  board memory read strobe.
- `brd_addr`  out  POS_W  board memory read address.
- `brd_rdata`  in  6  square code {color, type[4:0]}; valid the cycle after `brd_rd_en`.
- `piece_reg`  out  6  square code presented to the transmitter.
- `pos_reg`  out  POS_W  square index of `piece_reg`.
- `pc_valid`  out  1  `piece_reg`/`pos_reg` valid.
- `pc_ready`  in  1  transmitter accepts the current pair.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at scan end.
- `piece_count`  out  5  number of pairs accepted in the current or last scan (0..16 for legal boards; saturates at 31).

## Operation
- Type codes: EMPTY 00000, KNIGHT 00001, PAWN 00010, KING 00100, BISHOP 01000, ROOK 10000, QUEEN 11000. Any other value is illegal.
- FSM states: IDLE, FETCH, CHECK, EMIT, DONE.
- IDLE: when `start`=1, latch `color_q`=`engine_color`, clear `piece_count`, set addr=0, go to FETCH.
- FETCH: `brd_rd_en`=1, `brd_addr`=addr; go to CHECK.
- CHECK: capture `brd_rdata`→`piece_reg` and addr→`pos_reg`.
  - If the square qualifies, go to EMIT.
  - Else if addr==SQUARES-1, go to DONE.
  - Else addr+1, go to FETCH.
- EMIT: `pc_valid`=1; `piece_reg`/`pos_reg` are held stable until `pc_ready`. On `pc_valid`&&`pc_ready`: increment `piece_count` (saturating), then go to DONE if addr==SQUARES-1, else addr+1 and FETCH.
- DONE: `done`=1 for one cycle, then IDLE. `piece_count` holds until the next accepted start.
- `start` while busy: ignored.
- `abort` (any non-IDLE state): next state is IDLE. `pc_valid` drops and `done` is not pulsed. `piece_count` holds its partial value. `abort` has priority over every other transition, including `pc_ready`.
- Qualification is defined under Configuration.
- Reset: state IDLE. `brd_rd_en`, `brd_addr`, `piece_reg`, `pos_reg`, `pc_valid`, `busy`, `done`, `piece_count` and `color_q` are all 0. Reset mid-scan discards the scan with no `done`.

## Timing
- Start sampled at edge k: FETCH for square n occurs in cycle k+1+2n+e, where e = number of EMIT cycles before square n. CHECK follows in the next cycle.
- Skipped square: 2 cycles. Forwarded square with `pc_ready` held high: 3 cycles. Each stalled cycle adds 1 cycle.
- Empty board: `done` in cycle k+129; `busy` falls at k+130.
- `pc_valid` is registered: it rises the cycle after CHECK and falls the cycle after acceptance.
- All outputs are registered; there is no combinational path from `pc_ready` to outputs.

## Configuration
- `BOARD_SCAN_FILTER_EN` defined: a square qualifies only if its type is non-EMPTY, its type is legal, and bit 5 == `color_q`. Empty, opponent and illegal squares are never presented.
- Not defined: every square qualifies. All 64 pairs are presented, and `piece_count` saturates at 31.

## Structure
- Shared package `chess_pkg`:
  - type-code constants (EMPTY..QUEEN), WHITE/BLACK, SQUARES;
  - FSM state enum;
  - `is_legal_type()` function, also used by the transmitter.
- No sub-module. This is a single FSM plus address counter and output registers.

## Test plan
- Initial board, `engine_color`=1 (white on squares 0..15), filter on, `pc_ready`=1: 16 pairs with `pos_reg` 0..15 in order, `piece_count`=16, `done` at k+145.
- Same board, `engine_color`=0: pairs at squares 48..63 only, `piece_count`=16. No white codes appear.
- Single white rook (6'b110000) at square 63, `pc_ready` low for 5 cycles: `pc_valid` held 6 cycles with stable pair {110000, 63}. `done` follows one cycle after acceptance.
- Square 20 = 6'b100111 (illegal), filter on: not presented, `piece_count`=0. Filter off: presented unchanged at `pos_reg`=20.
- `abort` asserted during EMIT at square 8: IDLE next cycle, no `done`, `piece_count` holds. A new `start` then clears `piece_count` and rescans from 0.
- `rst` pulsed mid-FETCH: all outputs 0 immediately. `start` during busy has no effect on the sequence.
